// File: rtl/congestion_detector_if.sv
// -----------------------------------------------------------------------------
// congestion_detector_if
//
// Purpose : Groups the sensor inputs and controller-facing outputs of the
//           congestion detector into one bundle.
//
// Signals :
//   car_in      raw entry-loop sensor level (high = vehicle present)
//   car_out     raw exit-loop sensor level  (high = vehicle present)
//   congestion  registered congestion flag for the light controller
//   occupancy   registered vehicle count between the loops (CNT_W bits)
//   count_err   sticky counter saturation / underflow flag
//
// Modports:
//   master  drives the sensors, observes the outputs (environment / bench)
//   slave   consumes the sensors, drives the outputs (detector)
// -----------------------------------------------------------------------------
interface congestion_detector_if #(
  parameter int unsigned CNT_W = 8
);

  logic             car_in;
  logic             car_out;
  logic             congestion;
  logic [CNT_W-1:0] occupancy;
  logic             count_err;

  modport master (
    output car_in,
    output car_out,
    input  congestion,
    input  occupancy,
    input  count_err
  );

  modport slave (
    input  car_in,
    input  car_out,
    output congestion,
    output occupancy,
    output count_err
  );

endinterface : congestion_detector_if

// File: rtl/congestion_detector.sv
// -----------------------------------------------------------------------------
// congestion_detector
//
// Purpose : Upstream feeder for the junction traffic-light controller. Turns
//           the raw entry/exit loop sensor levels into a debounced vehicle
//           occupancy count, and drives the controller's congestion input
//           through a hysteresis FSM with a hold time so that sensor glitches
//           or momentary queue spikes never reach the light sequence.
//
// Ports   :
//   clock    in   single clock, all state updates on the rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of congestion_detector_if
//              car_in / car_out     raw asynchronous sensor levels
//              congestion           registered, to the controller
//              occupancy            registered vehicle count
//              count_err            sticky saturation / underflow flag
//
// Build option:
//   CONG_DEBOUNCE_EN  when defined, each synchronized sensor passes through a
//                     persistence filter of DEBOUNCE cycles; when undefined
//                     the synchronized level is used directly and DEBOUNCE is
//                     ignored.
// -----------------------------------------------------------------------------
module congestion_detector #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned HIGH_TH  = 12,
  parameter int unsigned LOW_TH   = 6,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned HOLD_CYC = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  congestion_detector_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Parameter sanity (elaboration time only)
  // ---------------------------------------------------------------------------
  if (LOW_TH >= HIGH_TH) begin : g_chk_thresholds
    $error("congestion_detector: LOW_TH must be below HIGH_TH");
  end
  if (HIGH_TH > (2 ** CNT_W) - 1) begin : g_chk_high_range
    $error("congestion_detector: HIGH_TH does not fit in CNT_W bits");
  end
  if (DEBOUNCE < 1) begin : g_chk_debounce
    $error("congestion_detector: DEBOUNCE must be at least 1");
  end
  if (HOLD_CYC < 1) begin : g_chk_hold
    $error("congestion_detector: HOLD_CYC must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [CNT_W-1:0]  OCC_MAX   = '1;
  localparam logic [CNT_W-1:0]  HIGH_V    = CNT_W'(HIGH_TH);
  localparam logic [CNT_W-1:0]  LOW_V     = CNT_W'(LOW_TH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,       // congestion = 0, occupancy below HIGH_TH
    ST_ARMING,     // congestion = 0, counting qualifying samples to assert
    ST_CONGESTED,  // congestion = 1, occupancy above LOW_TH
    ST_CLEARING    // congestion = 1, counting qualifying samples to clear
  } state_t;

  // ---------------------------------------------------------------------------
  // Sensor input path. Bit 0 = entry loop, bit 1 = exit loop.
  // ---------------------------------------------------------------------------
  logic [1:0] raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] filt;         // accepted (filtered) sensor level
  logic [1:0] filt_prev_q;  // filtered level one cycle ago, for edge detect
  logic [1:0] event_p;      // one-cycle pulse on filtered 0->1

  assign raw = {bus.car_out, bus.car_in};

  // Two-flop synchronizer plus the previous-filtered-level register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_prev_q <= '0;
    end else begin
      // NOTE: non-blocking so sync2_q captures the value sync1_q held before
      // this edge; blocking here would collapse the two stages into one.
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt;
    end
  end

`ifdef CONG_DEBOUNCE_EN
  // Persistence filter: the counter runs while the synchronized level
  // disagrees with the accepted level, and the accepted level only follows
  // once the disagreement has lasted DEBOUNCE cycles. Any agreeing cycle
  // throws the partial count away.
  localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [1:0]            filt_q;
  logic [1:0]            filt_d;
  logic [1:0][DEB_W-1:0] deb_cnt_q;
  logic [1:0][DEB_W-1:0] deb_cnt_d;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          // This cycle is the DEBOUNCE-th disagreement: accept the level.
          filt_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q    <= '0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign filt = filt_q;
`else
  // No filter: every synchronized rising edge is accepted.
  assign filt = sync2_q;
`endif

  assign event_p = filt & ~filt_prev_q;

  // ---------------------------------------------------------------------------
  // Occupancy counter with saturation and a sticky error flag
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic             err_q;
  logic             err_d;

  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    case (event_p)
      2'b01: begin  // entry only
        if (occ_q == OCC_MAX) err_d = 1'b1;
        else                  occ_d = occ_q + 1'b1;
      end
      2'b10: begin  // exit only
        if (occ_q == '0) err_d = 1'b1;
        else             occ_d = occ_q - 1'b1;
      end
      default: ;    // none, or entry and exit together: net change is zero
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hysteresis FSM with hold time. Occupancy strictly between LOW_TH and
  // HIGH_TH qualifies for neither direction, so it never moves congestion.
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              cong_q;
  logic              occ_hi;
  logic              occ_lo;

  assign occ_hi = (occ_q >= HIGH_V);
  assign occ_lo = (occ_q <= LOW_V);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (occ_hi) begin
          state_d = ST_ARMING;
          hold_d  = '0;
        end
      end
      ST_ARMING: begin
        // A single non-qualifying sample abandons the attempt entirely.
        if (!occ_hi) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_CONGESTED;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_CONGESTED: begin
        if (occ_lo) begin
          state_d = ST_CLEARING;
          hold_d  = '0;
        end
      end
      ST_CLEARING: begin
        if (!occ_lo) begin
          state_d = ST_CONGESTED;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  // Congestion is decoded from the next state so it changes on the very edge
  // the FSM enters CONGESTED or leaves CLEARING.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      cong_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cong_q  <= (state_d == ST_CONGESTED) || (state_d == ST_CLEARING);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.occupancy  = occ_q;
  assign bus.count_err  = err_q;
  assign bus.congestion = cong_q;

endmodule : congestion_detector

// File: tb/tb_congestion_detector.sv
// -----------------------------------------------------------------------------
// tb_congestion_detector
//
// Self-checking bench for congestion_detector. A reference model keeps the
// expected occupancy, error flag and congestion flag: sensor pulses are turned
// into scheduled count events at the documented latency, occupancy is a
// saturating integer, and congestion follows run lengths of consecutive
// qualifying occupancy samples. Honours CONG_DEBOUNCE_EN like the design.
// -----------------------------------------------------------------------------
module tb_congestion_detector;

  localparam int CNT_W    = 8;
  localparam int HIGH_TH  = 12;
  localparam int LOW_TH   = 6;
  localparam int DEBOUNCE = 3;
  localparam int HOLD_CYC = 16;
  localparam int OCC_MAX  = (1 << CNT_W) - 1;

`ifdef CONG_DEBOUNCE_EN
  localparam int LAT    = 3 + DEBOUNCE;  // raise -> occupancy update, edges
  localparam int MIN_HI = DEBOUNCE;      // shortest pulse that counts
  localparam int GAP    = DEBOUNCE + 1;  // safe low time between pulses
`else
  localparam int LAT    = 3;
  localparam int MIN_HI = 1;
  localparam int GAP    = 1;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  congestion_detector_if #(.CNT_W(CNT_W)) bus ();

  congestion_detector #(
    .CNT_W   (CNT_W),
    .HIGH_TH (HIGH_TH),
    .LOW_TH  (LOW_TH),
    .DEBOUNCE(DEBOUNCE),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int cyc    = 0;        // rising edges seen out of reset
  bit ev_in  [int];      // edge number -> entry counted on that edge
  bit ev_out [int];      // edge number -> exit counted on that edge
  int m_occ  = 0;
  bit m_err  = 1'b0;
  bit m_cong = 1'b0;
  int run_hi = 0;        // consecutive edges that sampled occ >= HIGH_TH
  int run_lo = 0;        // consecutive edges that sampled occ <= LOW_TH

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_occ  = 0;
      m_err  = 1'b0;
      m_cong = 1'b0;
      run_hi = 0;
      run_lo = 0;
      ev_in.delete();
      ev_out.delete();
    end else begin
      cyc++;
      // Congestion decisions use the occupancy held before this edge.
      run_hi = (m_occ >= HIGH_TH) ? run_hi + 1 : 0;
      run_lo = (m_occ <= LOW_TH)  ? run_lo + 1 : 0;
      if (!m_cong && run_hi >= HOLD_CYC + 1)     m_cong = 1'b1;
      else if (m_cong && run_lo >= HOLD_CYC + 1) m_cong = 1'b0;
      if (ev_in.exists(cyc) && !ev_out.exists(cyc)) begin
        if (m_occ == OCC_MAX) m_err = 1'b1;
        else                  m_occ++;
      end else if (ev_out.exists(cyc) && !ev_in.exists(cyc)) begin
        if (m_occ == 0) m_err = 1'b1;
        else            m_occ--;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  // Raise the chosen sensors just after an edge for hi edges, then hold them
  // low for lo edges. ev_edge returns the edge on which the count changes,
  // or -1 when the pulse is too short to be accepted.
  task automatic pulse(input bit do_in, input bit do_out, input int hi,
                       input int lo, output int ev_edge);
    @(posedge clock);
    #1;
    bus.car_in  = do_in;
    bus.car_out = do_out;
    ev_edge = -1;
    if (hi >= MIN_HI) begin
      ev_edge = cyc + LAT;
      if (do_in)  ev_in[ev_edge]  = 1'b1;
      if (do_out) ev_out[ev_edge] = 1'b1;
    end
    repeat (hi) @(posedge clock);
    #1;
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    repeat (lo) @(posedge clock);
  endtask

  task automatic settle();
    repeat (LAT) @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    n_checks++;
    if (bus.occupancy !== '0) $display("FAIL reset_occ got=%0d exp=0", bus.occupancy);
    else n_pass++;
    n_checks++;
    if (bus.congestion !== 1'b0) $display("FAIL reset_cong got=%0b exp=0", bus.congestion);
    else n_pass++;
    n_checks++;
    if (bus.count_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", bus.count_err);
    else n_pass++;
  endtask

  // Ten-cycle entry pulse: occupancy must step to 1 exactly LAT edges after
  // the rise and not earlier.
  task automatic test_single_entry();
    int exp;
    @(posedge clock);
    #1;
    bus.car_in = 1'b1;
    ev_in[cyc + LAT] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock);
      if (e == 10) #1 bus.car_in = 1'b0;
      @(negedge clock);
      exp = (e >= LAT) ? 1 : 0;
      n_checks++;
      if (bus.occupancy !== CNT_W'(exp))
        $display("FAIL single_entry edge=%0d got=%0d exp=%0d", e, bus.occupancy, exp);
      else n_pass++;
    end
    repeat (GAP + 1) @(posedge clock);
  endtask

  // Three two-cycle entry pulses: rejected by the filter, counted without it.
  task automatic test_glitch();
    int base, exp, e;
    base = m_occ;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 2, GAP + 2, e);
    settle();
`ifdef CONG_DEBOUNCE_EN
    exp = base;
`else
    exp = base + 3;
`endif
    n_checks++;
    if (bus.occupancy !== CNT_W'(exp))
      $display("FAIL glitch_occ got=%0d exp=%0d", bus.occupancy, exp);
    else n_pass++;
  endtask

  // Entry and exit accepted on the same edge at occupancy 5.
  task automatic test_simultaneous();
    int e, n;
    n = 5 - m_occ;
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(5)) $display("FAIL simul_pre got=%0d exp=5", bus.occupancy);
    else n_pass++;
    pulse(1'b1, 1'b1, MIN_HI + 1, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(5)) $display("FAIL simul_occ got=%0d exp=5", bus.occupancy);
    else n_pass++;
    n_checks++;
    if (bus.count_err !== 1'b0) $display("FAIL simul_err got=%0b exp=0", bus.count_err);
    else n_pass++;
  endtask

  task automatic test_congestion();
    int  t12, t6, e;
    bit  exp;
    apply_reset();
    for (int i = 0; i < HIGH_TH; i++) pulse(1'b1, 1'b0, MIN_HI, GAP, t12);
    // Rise exactly HOLD_CYC+1 edges after occupancy reaches HIGH_TH.
    for (int n = 0; n < HOLD_CYC + 6; n++) begin
      @(negedge clock);
      exp = (cyc >= t12 + HOLD_CYC + 1);
      n_checks++;
      if (bus.congestion !== exp)
        $display("FAIL cong_rise edge=%0d got=%0b exp=%0b", cyc - t12, bus.congestion, exp);
      else n_pass++;
    end
    // Down to LOW_TH+1: inside the hysteresis band, congestion holds.
    for (int i = 0; i < HIGH_TH - LOW_TH - 1; i++) pulse(1'b0, 1'b1, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(LOW_TH + 1))
      $display("FAIL band_occ got=%0d exp=%0d", bus.occupancy, LOW_TH + 1);
    else n_pass++;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      n_checks++;
      if (bus.congestion !== 1'b1) $display("FAIL band_cong n=%0d got=%0b exp=1", n, bus.congestion);
      else n_pass++;
    end
    // Down to LOW_TH: falls HOLD_CYC+1 edges later.
    pulse(1'b0, 1'b1, MIN_HI, GAP, t6);
    for (int n = 0; n < HOLD_CYC + 6; n++) begin
      @(negedge clock);
      exp = (cyc < t6 + HOLD_CYC + 1);
      n_checks++;
      if (bus.congestion !== exp)
        $display("FAIL cong_fall edge=%0d got=%0b exp=%0b", cyc - t6, bus.congestion, exp);
      else n_pass++;
    end
    // Bounce HIGH_TH-1 <-> HIGH_TH every 8 edges: hold never completes.
    for (int i = 0; i < HIGH_TH - 1 - LOW_TH; i++) pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 1'b0, 4, 3, e);
      n_checks++;
      if (bus.congestion !== 1'b0) $display("FAIL toggle_up i=%0d got=%0b exp=0", i, bus.congestion);
      else n_pass++;
      pulse(1'b0, 1'b1, 4, 3, e);
      n_checks++;
      if (bus.congestion !== 1'b0) $display("FAIL toggle_dn i=%0d got=%0b exp=0", i, bus.congestion);
      else n_pass++;
    end
  endtask

  // Random entries, exits, simultaneous pairs, glitches and idle stretches,
  // compared against the model after every operation.
  task automatic test_random();
    int r, hi, lo, e;
    bit di, dout;
    for (int i = 0; i < 80; i++) begin
      r    = $urandom_range(0, 9);
      di   = (r <= 4) || (r == 9);
      dout = (r >= 5);
      hi   = (r == 8) ? 1 : MIN_HI + $urandom_range(0, 3);
      lo   = GAP + $urandom_range(0, 24);
      pulse(di, dout, hi, lo, e);
      @(negedge clock);
      n_checks++;
      if (bus.occupancy !== CNT_W'(m_occ))
        $display("FAIL rand_occ op=%0d got=%0d exp=%0d", i, bus.occupancy, m_occ);
      else n_pass++;
      n_checks++;
      if (bus.congestion !== m_cong)
        $display("FAIL rand_cong op=%0d got=%0b exp=%0b", i, bus.congestion, m_cong);
      else n_pass++;
      n_checks++;
      if (bus.count_err !== m_err)
        $display("FAIL rand_err op=%0d got=%0b exp=%0b", i, bus.count_err, m_err);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int e;
    apply_reset();
    pulse(1'b0, 1'b1, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== '0) $display("FAIL under_occ got=%0d exp=0", bus.occupancy);
    else n_pass++;
    n_checks++;
    if (bus.count_err !== 1'b1) $display("FAIL under_err got=%0b exp=1", bus.count_err);
    else n_pass++;
    apply_reset();
    for (int i = 0; i < OCC_MAX; i++) pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(OCC_MAX))
      $display("FAIL full_occ got=%0d exp=%0d", bus.occupancy, OCC_MAX);
    else n_pass++;
    n_checks++;
    if (bus.count_err !== 1'b0) $display("FAIL full_err got=%0b exp=0", bus.count_err);
    else n_pass++;
    pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(OCC_MAX))
      $display("FAIL sat_occ got=%0d exp=%0d", bus.occupancy, OCC_MAX);
    else n_pass++;
    n_checks++;
    if (bus.count_err !== 1'b1) $display("FAIL sat_err got=%0b exp=1", bus.count_err);
    else n_pass++;
    repeat (50) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.count_err !== 1'b1) $display("FAIL sticky_err got=%0b exp=1", bus.count_err);
    else n_pass++;
    apply_reset();
    @(negedge clock);
    n_checks++;
    if (bus.count_err !== 1'b0) $display("FAIL err_clear got=%0b exp=0", bus.count_err);
    else n_pass++;
  endtask

  // Asynchronous reset from CONGESTED at occupancy 20, then normal operation.
  task automatic test_reset_mid();
    int e;
    apply_reset();
    for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    repeat (HOLD_CYC + LAT + 4) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.congestion !== 1'b1 || bus.occupancy !== CNT_W'(20))
      $display("FAIL mid_pre cong=%0b occ=%0d exp cong=1 occ=20", bus.congestion, bus.occupancy);
    else n_pass++;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.occupancy !== '0) $display("FAIL mid_async_occ got=%0d exp=0", bus.occupancy);
    else n_pass++;
    n_checks++;
    if (bus.congestion !== 1'b0) $display("FAIL mid_async_cong got=%0b exp=0", bus.congestion);
    else n_pass++;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    pulse(1'b1, 1'b0, MIN_HI, GAP, e);
    settle();
    n_checks++;
    if (bus.occupancy !== CNT_W'(1)) $display("FAIL post_occ got=%0d exp=1", bus.occupancy);
    else n_pass++;
    repeat (HOLD_CYC + 4) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.congestion !== 1'b0) $display("FAIL post_cong got=%0b exp=0", bus.congestion);
    else n_pass++;
  endtask

  initial begin
    bus.car_in  = 1'b0;
    bus.car_out = 1'b0;
    test_reset();
    test_single_entry();
    test_glitch();
    test_simultaneous();
    test_congestion();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_congestion_detector
